garegga_snd_mailbox: RTL and testbench
======================================

// Module: garegga_snd_mailbox
// PURPOSE
//  Parametrised main-CPU -> Z80 sound-command mailbox replacing the single SOUNDLATCH byte plus INT/WAIT flip-flops.
//  Buffers DEPTH commands in a FIFO, raises the Z80 interrupt and gates main-CPU WAIT, and carries a Z80 -> main reply byte.
//  Sits between the 68k bus decode and the *_sound block.
//  Single clock domain: CLK96. The 68k-side strobes are already synchronised to CLK96.
// PARAMETERS
//  WIDTH        8   command/reply data width
//  DEPTH        4   FIFO entries; power of two, >=2; DEPTH=1 is not supported
//  INT_LEVEL    0   0: latched INT (set by push, cleared by INTA); 1: INT = FIFO non-empty
//  WAIT_ON_ACK  1   1: m_wait held from push until z_ack; 0: m_wait = full only
// PORTS
//  CLK96          in   1      sound-domain clock
//  RESET96        in   1      asynchronous, active-high reset
//  flush          in   1      sync clear of FIFO/INT/WAIT/overflow flag
//  m_wr           in   1      1-cycle push strobe from main CPU
//  m_din          in   WIDTH  command data
//  m_wait         out  1      main CPU must stall
//  m_rd_reply     in   1      1-cycle reply read strobe
//  m_reply        out  WIDTH  reply data
//  m_reply_valid  out  1      unread reply present
//  z_rd           in   1      1-cycle pop strobe (Z80 read of latch addr)
//  z_dout         out  WIDTH  FIFO head, first-word-fall-through
//  z_ack          in   1      1-cycle ack strobe (Z80 write to ack addr)
//  z_inta         in   1      INT acknowledge (iorq & m1)
//  z_int_n        out  1      Z80 INT, active low
//  z_reply_wr     in   1      1-cycle reply write strobe
//  z_reply_din    in   WIDTH  reply data
//  count          out  $clog2(DEPTH)+1  entries held
//  empty, full    out  1      FIFO status
//  overflow       out  1      sticky: push dropped because full
// BEHAVIOUR
//  Reset values: count=0, empty=1, full=0, z_dout=0, z_int_n=1, m_wait=0, m_reply=0, m_reply_valid=0, overflow=0.
//  Push: accepted if !full, or if full && z_rd in the same cycle (count unchanged).
//   Rejected push: data dropped, overflow<=1.
//  Pop: z_rd with !empty advances head; z_dout shows the new head next cycle.
//   z_rd on empty: no pop, z_dout holds its last value.
//   Push+pop on empty: push only; the word appears on z_dout the next cycle.
//  Pointers wrap modulo DEPTH. count is registered; full = (count==DEPTH).
//  INT_LEVEL=0: int_pend set on accepted push, cleared by z_inta; set wins on same cycle.
//  INT_LEVEL=1: z_int_n = empty (registered); z_inta is ignored.
//  WAIT_ON_ACK=1: wait_pend set on accepted push, cleared by z_ack; set wins on same cycle.
//   m_wait = wait_pend | full.
//  WAIT_ON_ACK=0: m_wait = full.
//  m_wait and z_int_n update 1 cycle after the causing strobe.
//  Reply: z_reply_wr loads m_reply and sets valid; m_rd_reply clears valid.
//   Both strobes in the same cycle: write wins, valid stays 1.
//  flush: empties FIFO, clears int_pend, wait_pend, overflow; reply untouched; z_dout holds.
//   flush has priority over push/pop in the same cycle.
//  RESET96 asserted mid-transfer: immediate return to reset values; FIFO contents are lost.
// CONFIGURATION
//  SNDMBX_STATS_EN defined: adds ports ovf_cnt[7:0] and udf_cnt[7:0].
//   ovf_cnt counts rejected pushes; udf_cnt counts z_rd on empty.
//   Both saturate at 8'hFF and are cleared by reset or flush.
//  SNDMBX_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  garegga_snd_defs.vh: default WIDTH/DEPTH, INT/WAIT mode constants shared with the *_sound blocks.
//  Sub-module snd_mbx_fifo: storage array, rd/wr pointers, count, first-word-fall-through head register.
//  Top level: INT/WAIT control, reply register, stats counters.
// TESTING
//  1. DEPTH=4: push A1,A2,A3 -> count=3, z_dout=A1, z_int_n=0.
//     z_inta -> z_int_n=1. 3x z_rd -> z_dout A2, A3, then empty=1.
//  2. Push 5 words at DEPTH=4 -> full=1, m_wait=1, 5th dropped, overflow=1.
//     With stats: ovf_cnt=1.
//  3. full + m_wr + z_rd in the same cycle -> count stays 4; new word is read out after the 3 older words.
//  4. WAIT_ON_ACK=1: push 55 -> m_wait=1. z_ack alone -> m_wait=0 next cycle.
//     z_ack + m_wr in the same cycle -> m_wait stays 1.
//  5. z_reply_wr 3C with m_rd_reply in the same cycle -> m_reply=3C, m_reply_valid=1.
//     Later m_rd_reply alone -> valid=0.
//  6. RESET96 pulse with 2 entries queued and int pending -> count=0, z_int_n=1, m_wait=0, z_dout=0.
//     flush -> same clearing; m_reply is kept.

Source files
------------

// File: rtl/garegga_snd_mailbox_pkg.sv
// ============================================================================
// Module  : garegga_snd_mailbox_pkg
// Brief   : Shared defaults, mode constants and helpers for the sound mailbox.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package garegga_snd_mailbox_pkg;

  localparam int C_DEF_WIDTH        = 8;
  localparam int C_DEF_DEPTH        = 4;
  localparam int C_INT_MODE_LATCHED = 0;
  localparam int C_INT_MODE_LEVEL   = 1;
  localparam int C_WAIT_MODE_FULL   = 0;
  localparam int C_WAIT_MODE_ACK    = 1;

  // Qualified per-cycle FIFO events, already gated by flush and FIFO status
  typedef struct packed {
    logic push;
    logic pop;
    logic reject;
  } mbx_ev_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/garegga_snd_mailbox_fifo.sv
// ============================================================================
// Module  : snd_mbx_fifo
// Brief   : Command FIFO with registered first-word-fall-through head output.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module snd_mbx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic [AW-1:0]    w_rd_nxt;

  assign w_rd_nxt = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (!i_flush && i_push)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= w_rd_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // The slot after the head is stale when it is the one being written now
      if (i_pop && (r_count > CW'(1)))
        r_head <= r_mem[w_rd_nxt];
      else if (i_push && ((r_count == '0) || i_pop))
        r_head <= i_din;
    end
  end

  assign o_dout  = r_head;
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/garegga_snd_mailbox.sv
// ============================================================================
// Module  : garegga_snd_mailbox
// Brief   : Main CPU -> Z80 command mailbox with INT/WAIT control and reply.
//           Optional SNDMBX_STATS_EN adds overflow/underflow counters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module garegga_snd_mailbox
  import garegga_snd_mailbox_pkg::*;
#(
  parameter int WIDTH       = C_DEF_WIDTH,
  parameter int DEPTH       = C_DEF_DEPTH,
  parameter int INT_LEVEL   = C_INT_MODE_LATCHED,
  parameter int WAIT_ON_ACK = C_WAIT_MODE_ACK
) (
  input  logic                   CLK96,
  input  logic                   RESET96,
  input  logic                   flush,
  input  logic                   m_wr,
  input  logic [WIDTH-1:0]       m_din,
  output logic                   m_wait,
  input  logic                   m_rd_reply,
  output logic [WIDTH-1:0]       m_reply,
  output logic                   m_reply_valid,
  input  logic                   z_rd,
  output logic [WIDTH-1:0]       z_dout,
  input  logic                   z_ack,
  input  logic                   z_inta,
  output logic                   z_int_n,
  input  logic                   z_reply_wr,
  input  logic [WIDTH-1:0]       z_reply_din,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
`ifdef SNDMBX_STATS_EN
  ,
  output logic [7:0]             ovf_cnt,
  output logic [7:0]             udf_cnt
`endif
);

  mbx_ev_t          w_ev;
  logic             r_overflow;
  logic [WIDTH-1:0] r_reply;
  logic             r_reply_valid;

  // A push into a full FIFO still lands when the Z80 frees a slot the same cycle
  assign w_ev.push   = m_wr & ~flush & (~full | z_rd);
  assign w_ev.pop    = z_rd & ~flush & ~empty;
  assign w_ev.reject = m_wr & ~flush & full & ~z_rd;

  snd_mbx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK96),
    .rst     (RESET96),
    .i_flush (flush),
    .i_push  (w_ev.push),
    .i_pop   (w_ev.pop),
    .i_din   (m_din),
    .o_dout  (z_dout),
    .o_count (count),
    .o_empty (empty),
    .o_full  (full)
  );

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)          r_overflow <= 1'b0;
    else if (flush)       r_overflow <= 1'b0;
    else if (w_ev.reject) r_overflow <= 1'b1;
  end
  assign overflow = r_overflow;

  generate
    if (INT_LEVEL == C_INT_MODE_LEVEL) begin : g_int_level
      assign z_int_n = empty;
    end else begin : g_int_latched
      logic r_int_pend;
      always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96)        r_int_pend <= 1'b0;
        else if (flush)     r_int_pend <= 1'b0;
        else if (w_ev.push) r_int_pend <= 1'b1;
        else if (z_inta)    r_int_pend <= 1'b0;
      end
      assign z_int_n = ~r_int_pend;
    end
  endgenerate

  generate
    if (WAIT_ON_ACK == C_WAIT_MODE_ACK) begin : g_wait_ack
      logic r_wait_pend;
      always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96)        r_wait_pend <= 1'b0;
        else if (flush)     r_wait_pend <= 1'b0;
        else if (w_ev.push) r_wait_pend <= 1'b1;
        else if (z_ack)     r_wait_pend <= 1'b0;
      end
      assign m_wait = r_wait_pend | full;
    end else begin : g_wait_full
      assign m_wait = full;
    end
  endgenerate

  // Reply path is independent of flush
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_reply       <= '0;
      r_reply_valid <= 1'b0;
    end else if (z_reply_wr) begin
      r_reply       <= z_reply_din;
      r_reply_valid <= 1'b1;
    end else if (m_rd_reply) begin
      r_reply_valid <= 1'b0;
    end
  end
  assign m_reply       = r_reply;
  assign m_reply_valid = r_reply_valid;

`ifdef SNDMBX_STATS_EN
  logic       w_underrun;
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_udf_cnt;

  assign w_underrun = z_rd & ~flush & empty;

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_ovf_cnt <= 8'h00;
      r_udf_cnt <= 8'h00;
    end else if (flush) begin
      r_ovf_cnt <= 8'h00;
      r_udf_cnt <= 8'h00;
    end else begin
      if (w_ev.reject) r_ovf_cnt <= sat_inc8(r_ovf_cnt);
      if (w_underrun)  r_udf_cnt <= sat_inc8(r_udf_cnt);
    end
  end
  assign ovf_cnt = r_ovf_cnt;
  assign udf_cnt = r_udf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_garegga_snd_mailbox.sv
// ============================================================================
// Module  : tb_garegga_snd_mailbox
// Brief   : Directed self-checking bench for garegga_snd_mailbox (DEPTH=4).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_garegga_snd_mailbox;

  localparam int DEPTH = 4;

  logic       CLK96 = 1'b0;
  logic       RESET96 = 1'b0;
  logic       flush = 1'b0;
  logic       m_wr = 1'b0;
  logic [7:0] m_din = 8'h00;
  logic       m_wait;
  logic       m_rd_reply = 1'b0;
  logic [7:0] m_reply;
  logic       m_reply_valid;
  logic       z_rd = 1'b0;
  logic [7:0] z_dout;
  logic       z_ack = 1'b0;
  logic       z_inta = 1'b0;
  logic       z_int_n;
  logic       z_reply_wr = 1'b0;
  logic [7:0] z_reply_din = 8'h00;
  logic [2:0] count;
  logic       empty, full, overflow;
`ifdef SNDMBX_STATS_EN
  logic [7:0] ovf_cnt, udf_cnt;
`endif

  always #5 CLK96 = ~CLK96;

  garegga_snd_mailbox dut (
    .CLK96         (CLK96),
    .RESET96       (RESET96),
    .flush         (flush),
    .m_wr          (m_wr),
    .m_din         (m_din),
    .m_wait        (m_wait),
    .m_rd_reply    (m_rd_reply),
    .m_reply       (m_reply),
    .m_reply_valid (m_reply_valid),
    .z_rd          (z_rd),
    .z_dout        (z_dout),
    .z_ack         (z_ack),
    .z_inta        (z_inta),
    .z_int_n       (z_int_n),
    .z_reply_wr    (z_reply_wr),
    .z_reply_din   (z_reply_din),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow)
`ifdef SNDMBX_STATS_EN
    ,
    .ovf_cnt       (ovf_cnt),
    .udf_cnt       (udf_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the mailbox as a queue plus a few flags
  logic [7:0] mq[$];
  bit         md_intp, md_waitp, md_ovf, md_valid;
  logic [7:0] md_dout, md_reply;
  int         md_ovfc, md_udfc;
  bit         check_en = 1'b0;

  function automatic void model_reset();
    mq.delete();
    md_intp = 0; md_waitp = 0; md_ovf = 0; md_valid = 0;
    md_dout = 8'h00; md_reply = 8'h00; md_ovfc = 0; md_udfc = 0;
  endfunction

  function automatic void model_update();
    bit was_full, was_empty, do_push, do_pop;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (flush) begin
      mq.delete();
      md_intp = 0; md_waitp = 0; md_ovf = 0; md_ovfc = 0; md_udfc = 0;
    end else begin
      do_pop  = z_rd && !was_empty;
      do_push = m_wr && (!was_full || z_rd);
      if (z_rd && was_empty && md_udfc < 255) md_udfc++;
      if (m_wr && !do_push) begin
        md_ovf = 1;
        if (md_ovfc < 255) md_ovfc++;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(m_din);
      if (mq.size() > 0) md_dout = mq[0];
      if (do_push) md_intp = 1; else if (z_inta) md_intp = 0;
      if (do_push) md_waitp = 1; else if (z_ack) md_waitp = 0;
    end
    if (z_reply_wr) begin
      md_reply = z_reply_din;
      md_valid = 1;
    end else if (m_rd_reply) begin
      md_valid = 0;
    end
  endfunction

  always @(negedge CLK96) begin
    if (check_en && !RESET96) begin
      chk("m_count",    32'(count),         32'(mq.size()));
      chk("m_empty",    32'(empty),         32'(mq.size() == 0));
      chk("m_full",     32'(full),          32'(mq.size() == DEPTH));
      chk("m_z_dout",   32'(z_dout),        32'(md_dout));
      chk("m_z_int_n",  32'(z_int_n),       32'(!md_intp));
      chk("m_m_wait",   32'(m_wait),        32'(md_waitp || (mq.size() == DEPTH)));
      chk("m_overflow", 32'(overflow),      32'(md_ovf));
      chk("m_reply",    32'(m_reply),       32'(md_reply));
      chk("m_valid",    32'(m_reply_valid), 32'(md_valid));
`ifdef SNDMBX_STATS_EN
      chk("m_ovf_cnt",  32'(ovf_cnt),       32'(md_ovfc));
      chk("m_udf_cnt",  32'(udf_cnt),       32'(md_udfc));
`endif
    end
  end

  task automatic tick();
    @(posedge CLK96);
    model_update();
    #1;
    flush = 0; m_wr = 0; m_rd_reply = 0; z_rd = 0;
    z_ack = 0; z_inta = 0; z_reply_wr = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count),         32'd0);
    chk({tag, "_empty"}, 32'(empty),         32'd1);
    chk({tag, "_full"},  32'(full),          32'd0);
    chk({tag, "_dout"},  32'(z_dout),        32'h00);
    chk({tag, "_intn"},  32'(z_int_n),       32'd1);
    chk({tag, "_wait"},  32'(m_wait),        32'd0);
    chk({tag, "_reply"}, 32'(m_reply),       32'h00);
    chk({tag, "_valid"}, 32'(m_reply_valid), 32'd0);
    chk({tag, "_ovf"},   32'(overflow),      32'd0);
  endtask

  initial begin
    model_reset();
    #1 RESET96 = 1;
    #2 chk_reset_vals("rst0");
    repeat (2) @(posedge CLK96);
    #1 RESET96 = 0;
    check_en = 1;

    // 1: three pushes, INT acknowledge, drain
    m_wr = 1; m_din = 8'hA1; tick();
    m_wr = 1; m_din = 8'hA2; tick();
    m_wr = 1; m_din = 8'hA3; tick();
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_dout",  32'(z_dout), 32'hA1);
    chk("t1_intn",  32'(z_int_n), 32'd0);
    z_inta = 1; tick();
    chk("t1_inta", 32'(z_int_n), 32'd1);
    z_rd = 1; tick(); chk("t1_pop1", 32'(z_dout), 32'hA2);
    z_rd = 1; tick(); chk("t1_pop2", 32'(z_dout), 32'hA3);
    z_rd = 1; tick(); chk("t1_empty", 32'(empty), 32'd1);
    z_rd = 1; tick(); chk("t1_udf_hold", 32'(z_dout), 32'hA3);
    z_ack = 1; tick(); chk("t1_ack", 32'(m_wait), 32'd0);

    // 2: five pushes into four slots
    for (int i = 0; i < 5; i++) begin
      m_wr = 1; m_din = 8'hB0 + 8'(i); tick();
    end
    chk("t2_full",  32'(full), 32'd1);
    chk("t2_wait",  32'(m_wait), 32'd1);
    chk("t2_ovf",   32'(overflow), 32'd1);
    chk("t2_count", 32'(count), 32'd4);
`ifdef SNDMBX_STATS_EN
    chk("t2_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif

    // 3: push and pop together while full
    m_wr = 1; m_din = 8'hC0; z_rd = 1; tick();
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_dout0", 32'(z_dout), 32'hB1);
    z_rd = 1; tick(); chk("t3_dout1", 32'(z_dout), 32'hB2);
    z_rd = 1; tick(); chk("t3_dout2", 32'(z_dout), 32'hB3);
    z_rd = 1; tick(); chk("t3_dout3", 32'(z_dout), 32'hC0);
    z_rd = 1; tick(); chk("t3_empty", 32'(empty), 32'd1);
    flush = 1; tick();
    chk("t3_fl_ovf",  32'(overflow), 32'd0);
    chk("t3_fl_wait", 32'(m_wait), 32'd0);
    chk("t3_fl_hold", 32'(z_dout), 32'hC0);

    // 4: WAIT held until ack; push wins over ack
    m_wr = 1; m_din = 8'h55; tick(); chk("t4_wait1", 32'(m_wait), 32'd1);
    z_ack = 1; tick();               chk("t4_ack",   32'(m_wait), 32'd0);
    z_ack = 1; m_wr = 1; m_din = 8'h66; tick();
    chk("t4_ackwr", 32'(m_wait), 32'd1);

    // 5: reply path
    z_reply_wr = 1; z_reply_din = 8'h3C; m_rd_reply = 1; tick();
    chk("t5_reply", 32'(m_reply), 32'h3C);
    chk("t5_valid", 32'(m_reply_valid), 32'd1);
    m_rd_reply = 1; tick();
    chk("t5_rd", 32'(m_reply_valid), 32'd0);

    // 6: asynchronous reset mid-cycle with two entries and INT pending
    chk("t6_pre_count", 32'(count), 32'd2);
    #2 RESET96 = 1;
    model_reset();
    #1 chk_reset_vals("t6_rst");
    #2 RESET96 = 0;
    z_reply_wr = 1; z_reply_din = 8'h5A; tick();
    m_wr = 1; m_din = 8'h11; tick();
    m_wr = 1; m_din = 8'h22; tick();
    chk("t6_intn_pre", 32'(z_int_n), 32'd0);
    flush = 1; tick();
    chk("t6_fl_count", 32'(count), 32'd0);
    chk("t6_fl_intn",  32'(z_int_n), 32'd1);
    chk("t6_fl_wait",  32'(m_wait), 32'd0);
    chk("t6_fl_reply", 32'(m_reply), 32'h5A);
    chk("t6_fl_dout",  32'(z_dout), 32'h11);

    // push and pop together on empty: push only
    m_wr = 1; m_din = 8'h77; z_rd = 1; tick();
    chk("t7_count", 32'(count), 32'd1);
    chk("t7_dout",  32'(z_dout), 32'h77);

    @(negedge CLK96);
    #1;
    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
